// File: rtl/stall_ctrl_if.sv
// Decode-side handshake between the decode stage and the pipeline stall controller.
// The decode stage drives the instruction and control inputs; the stall controller returns bubble and PC-hold controls.
interface stall_ctrl_if;
    logic       instr_valid;
    logic [6:0] opc;
    logic       hold_in;
    logic       flush_in;
    logic       stall_en;
    logic       pc_en;
    logic       busy;

    modport master (
        output instr_valid,
        output opc,
        output hold_in,
        output flush_in,
        input  stall_en,
        input  pc_en,
        input  busy
    );

    modport slave (
        input  instr_valid,
        input  opc,
        input  hold_in,
        input  flush_in,
        output stall_en,
        output pc_en,
        output busy
    );
endinterface

// File: rtl/stall_ctrl.sv
// Registered pipeline stall controller: bubble/PC-hold countdowns for control-transfer and load
// instructions, with external hold, flush abort and a saturating stall-cycle statistic.
module stall_ctrl #(
    parameter int CTRL_FLUSH = 3,
    parameter int CTRL_HOLD  = 2,
    parameter int LOAD_FLUSH = 1,
    parameter int LOAD_HOLD  = 1,
    parameter int CNT_W      = 2,
    parameter int STAT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    stall_ctrl_if.slave       ctrl,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [CNT_W-1:0]  CTRL_FLUSH_C = CNT_W'(CTRL_FLUSH);
    localparam logic [CNT_W-1:0]  CTRL_HOLD_C  = CNT_W'(CTRL_HOLD);
    localparam logic [CNT_W-1:0]  LOAD_FLUSH_C = CNT_W'(LOAD_FLUSH);
    localparam logic [CNT_W-1:0]  LOAD_HOLD_C  = CNT_W'(LOAD_HOLD);
    localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_ONE     = STAT_W'(1);
    localparam logic [STAT_W-1:0] STAT_MAX     = '1;

    logic [CNT_W-1:0]  nop_cnt_q, nop_cnt_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic nop_zero;
    logic hold_zero;
    logic is_ctrl;
    logic is_load;
    logic accept;

    always_comb begin
        nop_zero  = (nop_cnt_q == '0);
        hold_zero = (hold_cnt_q == '0);
        is_ctrl   = (ctrl.opc == OPCODE_JAL) || (ctrl.opc == OPCODE_JALR) ||
                    (ctrl.opc == OPCODE_BRANCH);
        is_load   = (ctrl.opc == OPCODE_LOAD);
        // An opcode seen while a bubble is in flight belongs to a squashed slot.
        accept    = ctrl.instr_valid && !ctrl.hold_in && !ctrl.flush_in && nop_zero;
    end

    always_comb begin
        nop_cnt_d  = nop_cnt_q;
        hold_cnt_d = hold_cnt_q;
        if (ctrl.flush_in) begin
            nop_cnt_d  = '0;
            hold_cnt_d = '0;
        end else if (ctrl.hold_in) begin
            nop_cnt_d  = nop_cnt_q;
            hold_cnt_d = hold_cnt_q;
        end else if (accept && is_ctrl) begin
            nop_cnt_d  = CTRL_FLUSH_C;
            hold_cnt_d = CTRL_HOLD_C;
        end else if (accept && is_load) begin
            nop_cnt_d  = LOAD_FLUSH_C;
            hold_cnt_d = LOAD_HOLD_C;
        end else begin
            if (!nop_zero) begin
                nop_cnt_d = nop_cnt_q - CNT_ONE;
            end
            if (!hold_zero) begin
                hold_cnt_d = hold_cnt_q - CNT_ONE;
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stat_clr) begin
            stall_cycles_d = '0;
        end else if (!nop_zero && (stall_cycles_q != STAT_MAX)) begin
            stall_cycles_d = stall_cycles_q + STAT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nop_cnt_q      <= '0;
            hold_cnt_q     <= '0;
            stall_cycles_q <= '0;
        end else begin
            nop_cnt_q      <= nop_cnt_d;
            hold_cnt_q     <= hold_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // pc_en is the only output with a combinational path, through hold_in.
    assign ctrl.stall_en = !nop_zero;
    assign ctrl.pc_en    = hold_zero && !ctrl.hold_in;
    assign ctrl.busy     = !nop_zero || !hold_zero;
    assign stall_cycles  = stall_cycles_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: per-cycle expectations are queued as stimulus is driven and
// popped when the outputs settle; a second instance with a 2-bit statistic exercises saturation.
module tb_stall_ctrl;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic        iv;
        logic        hold;
        logic        flush;
        logic        clr;
        logic [6:0]  opc;
        logic [2:0]  flags;
        logic [15:0] cnt;
    } vec_t;

    typedef struct packed {
        logic [2:0]  flags;
        logic [15:0] cnt;
        logic [1:0]  cnt_sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stat_clr = 1'b0;
    logic [15:0] stall_cycles;
    logic [1:0]  stall_cycles_sat;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];

    stall_ctrl_if ifc ();
    stall_ctrl_if ifc_sat ();

    assign ifc_sat.instr_valid = ifc.instr_valid;
    assign ifc_sat.opc         = ifc.opc;
    assign ifc_sat.hold_in     = ifc.hold_in;
    assign ifc_sat.flush_in    = ifc.flush_in;

    stall_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl         (ifc.slave),
        .stat_clr     (stat_clr),
        .stall_cycles (stall_cycles)
    );

    stall_ctrl #(.STAT_W(2)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl         (ifc_sat.slave),
        .stat_clr     (stat_clr),
        .stall_cycles (stall_cycles_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // flags are {stall_en, pc_en, busy} expected during the cycle the inputs are applied.
    function automatic vec_t mk(input logic iv, input logic [6:0] opc, input logic hold,
                                input logic flush, input logic clr, input logic [2:0] flags,
                                input int cnt);
        vec_t v;
        v.iv    = iv;
        v.opc   = opc;
        v.hold  = hold;
        v.flush = flush;
        v.clr   = clr;
        v.flags = flags;
        v.cnt   = 16'(cnt);
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        ifc.instr_valid = v.iv;
        ifc.opc         = v.opc;
        ifc.hold_in     = v.hold;
        ifc.flush_in    = v.flush;
        stat_clr        = v.clr;
        e.flags   = v.flags;
        e.cnt     = v.cnt;
        e.cnt_sat = (v.cnt > 16'd3) ? 2'd3 : v.cnt[1:0];
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.instr_valid = 1'b0;
        ifc.opc         = OPC_OP;
        ifc.hold_in     = 1'b0;
        ifc.flush_in    = 1'b0;
        stat_clr        = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v[$];
        exp_t e;
        exp_t got;
        rst_n = 1'b0;
        v.push_back(mk(0, OPC_OP, 1, 0, 0, 3'b000, 0));
        v.push_back(mk(0, OPC_OP, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP, 0, 0, 0, 3'b010, 0));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL reset cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            if (i == 1) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_ctrl();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_JAL, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 1));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b111, 2));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b010, 3));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b010, 3));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL ctrl cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_nontrigger();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_OP,  0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_JAL, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(1, OPC_OP,  1, 0, 0, 3'b000, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b010, 0));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL nontrigger cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_squash();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_LOAD,   0, 0, 0, 3'b010, 0));
        v.push_back(mk(1, OPC_BRANCH, 0, 0, 0, 3'b101, 0));
        v.push_back(mk(0, OPC_OP,     0, 0, 0, 3'b010, 1));
        v.push_back(mk(0, OPC_OP,     0, 0, 0, 3'b010, 1));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL squash cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hold();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_BRANCH, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,     0, 0, 0, 3'b101, 0));
        v.push_back(mk(0, OPC_OP,     1, 0, 0, 3'b101, 1));
        v.push_back(mk(0, OPC_OP,     1, 0, 0, 3'b101, 2));
        v.push_back(mk(0, OPC_OP,     0, 0, 0, 3'b101, 3));
        v.push_back(mk(0, OPC_OP,     0, 0, 0, 3'b111, 4));
        v.push_back(mk(0, OPC_OP,     0, 0, 0, 3'b010, 5));
        v.push_back(mk(0, OPC_OP,     1, 0, 0, 3'b000, 5));
        v.push_back(mk(0, OPC_OP,     0, 0, 0, 3'b010, 5));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL hold cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_JALR, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,   0, 0, 0, 3'b101, 0));
        v.push_back(mk(1, OPC_JAL,  0, 1, 0, 3'b101, 1));
        v.push_back(mk(0, OPC_OP,   0, 0, 0, 3'b010, 2));
        v.push_back(mk(0, OPC_OP,   0, 0, 0, 3'b010, 2));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL flush cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_LOAD, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,   0, 0, 0, 3'b101, 0));
        v.push_back(mk(1, OPC_JAL,  0, 0, 0, 3'b010, 1));
        v.push_back(mk(0, OPC_OP,   0, 0, 0, 3'b101, 1));
        v.push_back(mk(0, OPC_OP,   0, 0, 0, 3'b101, 2));
        v.push_back(mk(1, OPC_LOAD, 0, 0, 0, 3'b111, 3));
        v.push_back(mk(1, OPC_LOAD, 0, 0, 0, 3'b010, 4));
        v.push_back(mk(0, OPC_OP,   0, 0, 0, 3'b101, 4));
        v.push_back(mk(0, OPC_OP,   0, 0, 0, 3'b010, 5));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL back_to_back cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stat_clr();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_JAL, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 1, 3'b101, 1));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b111, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b010, 1));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL stat_clr cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_JAL, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 1));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b010, 0));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            if (i == 3) begin
                rst_n = 1'b0;
                #1;
            end
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL reset_mid cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            if (i == 3) begin
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturation();
        vec_t v[$];
        exp_t e;
        exp_t got;
        do_reset();
        v.push_back(mk(1, OPC_JAL, 0, 0, 0, 3'b010, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 0));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 1));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b111, 2));
        v.push_back(mk(1, OPC_JAL, 0, 0, 0, 3'b010, 3));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 3));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b101, 4));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b111, 5));
        v.push_back(mk(0, OPC_OP,  0, 0, 0, 3'b010, 6));
        foreach (v[i]) begin
            applyStimulus(v[i]);
            #1;
            e   = exp_q.pop_front();
            got = {ifc.stall_en, ifc.pc_en, ifc.busy, stall_cycles, stall_cycles_sat};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL saturation cyc %0d: got flags=%b cnt=%0d sat=%0d, expected flags=%b cnt=%0d sat=%0d",
                         i, got.flags, got.cnt, got.cnt_sat, e.flags, e.cnt, e.cnt_sat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        ifc.instr_valid = 1'b0;
        ifc.opc         = OPC_OP;
        ifc.hold_in     = 1'b0;
        ifc.flush_in    = 1'b0;
        test_reset();
        test_ctrl();
        test_nontrigger();
        test_squash();
        test_hold();
        test_flush();
        test_back_to_back();
        test_stat_clr();
        test_reset_mid();
        test_saturation();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Registered, parametrised pipeline stall controller for the RISC-V core. It sits beside decode, watches the opcode of each valid decoded instruction, and drives bubble insertion (`stall_en`) and PC hold (`pc_en`) for control-transfer and load instructions. Unlike the earlier combinational stall logic, it holds its countdown state in flops and has configurable flush and hold lengths. It also accepts an external hold and a flush-abort, and keeps a saturating stall-cycle statistic.

## Interface

- `CTRL_FLUSH`, 3: bubble cycles after JAL/JALR/BRANCH
- `CTRL_HOLD`, 2: PC-hold cycles after JAL/JALR/BRANCH
- `LOAD_FLUSH`, 1: bubble cycles after LOAD
- `LOAD_HOLD`, 1: PC-hold cycles after LOAD
- `CNT_W`, 2: countdown width; all four lengths must be ≤ 2^CNT_W−1, and each HOLD ≤ its FLUSH
- `STAT_W`, 16: stall statistic width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_valid`  in  1  decode holds a real instruction
- `opc`  in  7  opcode of the decode-stage instruction (`OPCODE_*` from constants.vh)
- `hold_in`  in  1  external freeze (e.g. memory wait)
- `flush_in`  in  1  abort current stall sequence
- `stat_clr`  in  1  clear statistic
- `stall_en`  out  1  insert NOP into decode/execute
- `pc_en`  out  1  1 = PC may advance; 0 = PC held
- `busy`  out  1  either countdown nonzero
- `stall_cycles`  out  STAT_W  saturating count of cycles with `stall_en`=1

## Operation

- **State:** `nop_cnt[CNT_W]` and `hold_cnt[CNT_W]`. Outputs are decoded from the flops:
  - `stall_en` = (`nop_cnt`≠0)
  - `pc_en` = (`hold_cnt`==0) & ~`hold_in`
  - `busy` = (`nop_cnt`≠0) | (`hold_cnt`≠0)
- **Trigger classes:**
  - CTRL: `opc` ∈ {`OPCODE_JAL`, `OPCODE_JALR`, `OPCODE_BRANCH`}
  - LOAD: `opc` = `OPCODE_LOAD`
  - All other opcodes are non-triggering.
- **Accept condition:** `instr_valid` & ~`hold_in` & ~`flush_in` & (`nop_cnt`==0). An opcode seen while `stall_en`=1 belongs to a squashed slot and is ignored.
- **Per-edge update, in priority order:**
  1. `flush_in`=1: both counters ← 0.
  2. `hold_in`=1: both counters keep their value.
  3. Accepted CTRL: `nop_cnt`←`CTRL_FLUSH`, `hold_cnt`←`CTRL_HOLD`.
  4. Accepted LOAD: `nop_cnt`←`LOAD_FLUSH`, `hold_cnt`←`LOAD_HOLD`.
  5. Otherwise: each nonzero counter decrements by 1. Counters never wrap below 0.
- **Accept with `hold_cnt`≠0 but `nop_cnt`==0:** the reload overwrites `hold_cnt`; it is not summed.
- **Statistic:**
  - `stat_clr` → 0. This takes priority over increment.
  - Otherwise `stall_cycles` += 1 on each edge where `stall_en`=1.
  - Saturates at 2^STAT_W−1.
  - Unaffected by `flush_in`.
- **Reset (`rst_n`=0, asynchronous):**
  - Counters = 0, `stall_cycles` = 0.
  - Hence `stall_en`=0, `busy`=0, and `pc_en`=~`hold_in` (1 when `hold_in`=0).
  - Reset mid-sequence abandons the sequence immediately, with no residual stall.

## Timing

- Trigger sampled at edge T → `stall_en`=1 from T+ through `*_FLUSH` cycles; `pc_en`=0 for `*_HOLD` cycles starting at T+.
- Defaults:
  - CTRL gives `stall_en` high for 3 cycles and `pc_en` low for 2.
  - LOAD gives 1 cycle of each.
- Earliest re-trigger: the edge at which `nop_cnt` is 0 before the edge, i.e. the first cycle after the last bubble.
- `hold_in` stretches the sequence 1:1. `pc_en` drops combinationally in the same cycle `hold_in` rises.
- `flush_in` at edge T: outputs clear from T+. A triggering opcode presented in the same cycle is dropped.
- Zero-latency combinational path from the inputs to `pc_en` only (through `hold_in`). All other outputs come from flops.

## Test plan

- **Reset:** release `rst_n` with `hold_in`=0 → `stall_en`=0, `pc_en`=1, `busy`=0, `stall_cycles`=0.
- **CTRL sequence:** single valid JAL (7'b1101111) → `stall_en` 1,1,1,0 and `pc_en` 0,0,1,1 over the next four cycles; `stall_cycles`=3.
- **Squashed opcode:** LOAD (7'b0000011), then BRANCH on the next cycle while `stall_en`=1 → BRANCH ignored; `stall_en` high exactly 1 cycle.
- **External hold:** BRANCH, then `hold_in`=1 for 2 cycles after the first bubble → `stall_en` high 5 cycles total; `pc_en`=0 throughout the hold.
- **Flush abort:** JALR, then `flush_in` on the 2nd bubble cycle with a JAL present at decode → `stall_en`=0 next cycle and JAL not accepted; `stall_cycles`=2.
- **Reset and saturation:**
  - `rst_n` pulsed low mid-CTRL sequence → all counters and `stall_cycles` = 0 immediately, asynchronously.
  - With `STAT_W`=2, a CTRL sequence followed by another CTRL sequence → `stall_cycles` holds at 3.
